frame_reader: RTL and testbench

//  Read side of the on-chip double-buffered frame buffer. Game/draw logic writes
//  4-bit palette indices into the back buffer. This block fetches the front

---
 rtl/frame_reader.sv | 142 ++++++++++++++
 tb/tb_frame_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Front-buffer read pipeline: raster address generation, palette expansion,
// sync re-timing, and vsync-aligned buffer swap under a req/ack handshake.
//
// Swap FSM states
//   state | meaning
//   IDLE  | no swap requested; front_sel stable
//   PEND  | swap requested; waiting for the next vsync falling edge
//   ACK   | swap done, swap_ack high; waiting for swap_req to drop
module frame_reader #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 16,
  parameter int PIX_W       = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pixel_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_in,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_out
);

  localparam logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(FB_W * FB_H);

  typedef enum logic [1:0] {IDLE, PEND, ACK} swap_state_t;

  swap_state_t       state, state_next;
  logic              toggle;
  logic              vs_prev;
  logic              vs_fall;

  logic [ADDR_W-1:0] y_fb, x_fb, line_off, base, addr_next;
  logic              visible;

  logic [PIX_W-1:0]  pix_idx;
  logic [2:0]        hs_sr, vs_sr, blank_sr;
  logic [23:0]       rgb;
  logic [23:0]       pal [16];

  // Row stride of 160 built from shifts; all terms kept at full address width.
  always_comb begin
    y_fb      = ADDR_W'(DrawY >> SCALE_SHIFT);
    x_fb      = ADDR_W'(DrawX >> SCALE_SHIFT);
    line_off  = (y_fb << 7) + (y_fb << 5);
    base      = front_sel ? BUF1_BASE : '0;
    addr_next = base + line_off + x_fb;
    visible   = blank_in && (DrawX < 10'd640) && (DrawY < 10'd480);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
    end else if (pixel_en) begin
      rd_en <= visible;
      if (visible) rd_addr <= addr_next;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_idx  <= '0;
      rgb      <= '0;
      hs_sr    <= 3'b111;
      vs_sr    <= 3'b111;
      blank_sr <= 3'b000;
    end else if (pixel_en) begin
      pix_idx  <= rd_en ? rd_data : '0;
      // blank_sr[1] carries the blank of the pixel whose index is in pix_idx
      rgb      <= blank_sr[1] ? pal[pix_idx] : '0;
      hs_sr    <= {hs_sr[1:0], hs_in};
      vs_sr    <= {vs_sr[1:0], vs_in};
      blank_sr <= {blank_sr[1:0], blank_in};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) pal[i] <= {6{4'(i)}};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  assign Red       = rgb[23:16];
  assign Green     = rgb[15:8];
  assign Blue      = rgb[7:0];
  assign hs_out    = hs_sr[2];
  assign vs_out    = vs_sr[2];
  assign blank_out = blank_sr[2];

  assign vs_fall = pixel_en && !vs_in && vs_prev;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      vs_prev   <= 1'b1;
      front_sel <= 1'b0;
    end else begin
      state <= state_next;
      if (pixel_en) vs_prev <= vs_in;
      if (toggle) front_sel <= ~front_sel;
    end
  end

  // A request seen on the same edge as a vsync fall only reaches PEND,
  // so it waits for the following frame.
  always_comb begin
    state_next = state;
    toggle     = 1'b0;
    case (state)
      IDLE: if (swap_req) state_next = PEND;
      PEND: if (vs_fall) begin
        state_next = ACK;
        toggle     = 1'b1;
      end
      ACK:  if (!swap_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign swap_ack = (state == ACK);

endmodule

// File: tb/tb_frame_reader.sv
// Randomised and directed bench for frame_reader against a per-pixel
// reference model built from raster arithmetic and a history of strobes.
module tb_frame_reader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pixel_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        blank_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [3:0]  rd_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_rgb = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack, front_sel;
  logic [7:0]  Red, Green, Blue;
  logic        hs_out, vs_out, blank_out;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  bit pe_run = 1'b0;

  logic [3:0] mem [0:65535];

  frame_reader dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en),
    .DrawX(DrawX), .DrawY(DrawY), .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out)
  );

  always #5 Clk = ~Clk;

  // RAM port B: data for an address registered at edge T is sampled at T+2
  always @(posedge Clk) rd_data <= mem[rd_addr];

  initial forever begin
    @(posedge Clk);
    #2;
    if (pe_run) pixel_en = ~pixel_en;
    else pixel_en = 1'b0;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        en;
    logic [15:0] addr;
    logic        blank;
    logic        hs;
    logic        vs;
  } rec_t;

  rec_t        hist [3];
  rec_t        m_r;
  logic [23:0] m_pal [16];
  logic [23:0] m_rgb;
  logic [15:0] m_addr;
  logic [3:0]  m_idx;
  logic        m_en, m_fs, m_ack, m_pend, m_vsprev, m_fall;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) hist[i] = '{en: 1'b0, addr: 16'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1};
      for (int i = 0; i < 16; i++) m_pal[i] = {6{4'(i)}};
      m_rgb = '0; m_addr = '0; m_en = 1'b0;
      m_fs = 1'b0; m_ack = 1'b0; m_pend = 1'b0; m_vsprev = 1'b1;
    end else begin
      if (pixel_en) begin
        m_r.en    = blank_in && (DrawX < 640) && (DrawY < 480);
        m_r.addr  = 16'((m_fs ? 19200 : 0) + (int'(DrawY) / 4) * 160 + int'(DrawX) / 4);
        m_r.blank = blank_in;
        m_r.hs    = hs_in;
        m_r.vs    = vs_in;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = m_r;
        m_en = m_r.en;
        if (m_r.en) m_addr = m_r.addr;
        m_idx = hist[2].en ? mem[hist[2].addr] : 4'd0;
        m_rgb = hist[2].blank ? m_pal[m_idx] : 24'd0;
      end
      m_fall = pixel_en && !vs_in && m_vsprev;
      if (m_ack) begin
        if (!swap_req) m_ack = 1'b0;
      end else if (m_pend) begin
        if (m_fall) begin
          m_fs = ~m_fs; m_ack = 1'b1; m_pend = 1'b0;
        end
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      if (pixel_en) m_vsprev = vs_in;
      if (pal_we) m_pal[pal_idx] = pal_rgb;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("rgb", 32'({Red, Green, Blue}), 32'(m_rgb));
      chk("rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("rd_en", 32'(rd_en), 32'(m_en));
      chk("sync", 32'({hs_out, vs_out, blank_out}), 32'({hist[2].hs, hist[2].vs, hist[2].blank}));
      chk("swap_ack", 32'(swap_ack), 32'(m_ack));
      chk("front_sel", 32'(front_sel), 32'(m_fs));
    end
  end

  task automatic next_strobe();
    int n = 0;
    do begin
      @(posedge Clk);
      n++;
    end while (pixel_en !== 1'b1 && n < 8);
    if (pixel_en !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL strobe_wait actual=none required=pixel_en t=%0t", $time);
    end
    #3;
  endtask

  task automatic set_pix(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank_in = b;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 4'($urandom);
    mem[19199] = 4'hA;
    mem[38399] = 4'h5;
    mem[19361] = 4'h3;
    mem[161]   = 4'h3;

    repeat (3) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    chk_on = 1'b1;
    @(negedge Clk);
    chk("t1_rgb", 32'({Red, Green, Blue}), 32'h0);
    chk("t1_sync", 32'({hs_out, vs_out}), 32'h3);
    chk("t1_front_sel", 32'(front_sel), 32'h0);
    chk("t1_swap_ack", 32'(swap_ack), 32'h0);

    pe_run = 1'b1;
    set_pix(639, 479, 1'b1);
    hs_in = 1'b0;
    next_strobe();
    chk("t2_addr", 32'(rd_addr), 32'd19199);
    chk("t2_rd_en", 32'(rd_en), 32'h1);
    hs_in = 1'b1;
    set_pix(0, 0, 1'b1);
    next_strobe();
    set_pix(8, 8, 1'b1);
    next_strobe();
    chk("t3_rgb", 32'({Red, Green, Blue}), 32'hAAAAAA);
    chk("t3_hs_out", 32'(hs_out), 32'h0);

    set_pix(700, 8, 1'b1);
    next_strobe();
    chk("t4_rd_en_x", 32'(rd_en), 32'h0);
    chk("t4_addr_hold", 32'(rd_addr), 32'd322);
    set_pix(4, 4, 1'b0);
    next_strobe();
    chk("t4_rd_en_blank", 32'(rd_en), 32'h0);
    set_pix(0, 0, 1'b1);
    next_strobe();
    chk("t4_rgb_x", 32'({Red, Green, Blue}), 32'h0);
    next_strobe();
    chk("t4_rgb_blank", 32'({Red, Green, Blue}), 32'h0);

    vs_in = 1'b1;
    next_strobe();
    swap_req = 1'b1;
    repeat (3) next_strobe();
    chk("t5_no_early_swap", 32'(front_sel), 32'h0);
    vs_in = 1'b0;
    next_strobe();
    chk("t5_front_sel", 32'(front_sel), 32'h1);
    chk("t5_ack", 32'(swap_ack), 32'h1);
    vs_in = 1'b1;
    next_strobe();
    vs_in = 1'b0;
    next_strobe();
    chk("t5_single_swap", 32'(front_sel), 32'h1);
    swap_req = 1'b0;
    @(posedge Clk);
    #3;
    chk("t5_ack_drop", 32'(swap_ack), 32'h0);

    set_pix(639, 479, 1'b1);
    next_strobe();
    chk("t2_addr_buf1", 32'(rd_addr), 32'd38399);

    pal_idx = 4'd3;
    pal_rgb = 24'h123456;
    pal_we = 1'b1;
    @(posedge Clk);
    #3;
    pal_we = 1'b0;
    set_pix(4, 4, 1'b1);
    next_strobe();
    set_pix(0, 0, 1'b1);
    next_strobe();
    next_strobe();
    chk("t6_pal_write", 32'({Red, Green, Blue}), 32'h123456);

    set_pix(12, 0, 1'b1);
    next_strobe();
    #1;
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_rgb", 32'({Red, Green, Blue}), 32'h0);
    chk("t6_rst_addr", 32'({rd_addr, 3'b000, rd_en}), 32'h0);
    chk("t6_rst_sync", 32'({hs_out, vs_out, blank_out}), 32'h6);
    chk("t6_rst_swap", 32'({front_sel, swap_ack}), 32'h0);
    vs_in = 1'b1;
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    set_pix(4, 4, 1'b1);
    next_strobe();
    set_pix(0, 0, 1'b1);
    next_strobe();
    next_strobe();
    chk("t6_pal_reset", 32'({Red, Green, Blue}), 32'h333333);

    repeat (3000) begin
      set_pix($urandom_range(0, 799), $urandom_range(0, 524), ($urandom % 4) != 0);
      hs_in = ($urandom % 8) != 0;
      if ($urandom % 12 == 0) vs_in = ~vs_in;
      pal_we = ($urandom % 10) == 0;
      pal_idx = 4'($urandom);
      pal_rgb = 24'($urandom);
      if (!swap_req && !swap_ack && ($urandom % 6 == 0)) swap_req = 1'b1;
      else if (swap_req && swap_ack && ($urandom % 3 == 0)) swap_req = 1'b0;
      next_strobe();
    end
    pal_we = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
